// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared types and constants for the interrupt controller.
//   irq_state_t   - controller FSM states
//   REG_*         - register-port addresses
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_t;

  localparam logic [1:0] REG_ENABLE    = 2'd0;
  localparam logic [1:0] REG_PENDING   = 2'd1;
  localparam logic [1:0] REG_ACTIVE_ID = 2'd2;

endpackage

// File: rtl/irq_arbiter.sv
// irq_arbiter: combinational source selector.
//   cand       in  candidate sources (pending & enabled)
//   last_grant in  ID of the most recently acknowledged source
//   sel_id     out selected source ID (valid when any = 1)
//   any        out at least one candidate present
// RR_EN = 0: lowest set index wins. RR_EN = 1: search starts at last_grant+1.
module irq_arbiter #(
  parameter int NUM_SRC = 4,
  parameter bit RR_EN   = 1'b0,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] cand,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    sel_id,
  output logic               any
);

  always_comb begin
    int   start;
    int   idx;
    logic found;
    sel_id = '0;
    found  = 1'b0;
    start  = RR_EN ? (int'(last_grant) + 1) % NUM_SRC : 0;
    // Rotating scan; first hit from the start point wins.
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (start + k) % NUM_SRC;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        sel_id = ID_W'(idx);
      end
    end
  end

  assign any = |cand;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: NUM_SRC-input interrupt controller with a single
// request/ack/done handshake towards the core trap logic.
//   clk, rst        clock, synchronous active-high reset
//   src_i           interrupt lines (already synchronous)
//   reg_we/addr/wdata/rdata  register port: ENABLE, PENDING (W1C, edge only),
//                   ACTIVE_ID (read-only); rdata is combinational
//   irq_valid/irq_id  request and its source ID
//   irq_ack         core takes the trap (REQ only)
//   irq_done        core returned from the handler (ACTIVE only)
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC   = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
  parameter bit                 RR_EN     = 1'b0,
  parameter int                 ID_W      = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [NUM_SRC-1:0] reg_wdata,
  output logic [NUM_SRC-1:0] reg_rdata,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done
);

  irq_state_t         state_q, state_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] cand, w1c;
  logic [ID_W-1:0]    sel_id;
  logic               any, ack_take;

  assign cand     = pending_q & enable_q;
  assign ack_take = (state_q == REQ) && irq_ack;

  irq_arbiter #(.NUM_SRC(NUM_SRC), .RR_EN(RR_EN), .ID_W(ID_W)) u_arb (
    .cand      (cand),
    .last_grant(last_grant_q),
    .sel_id    (sel_id),
    .any       (any)
  );

  // State register plus all controller flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      enable_q     <= '0;
      pending_q    <= '0;
      src_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      last_grant_q <= last_grant_d;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      src_q        <= src_d;
    end
  end

  // Source tracking and software-visible registers.
  always_comb begin
    src_d        = src_i;
    enable_d     = enable_q;
    if (reg_we && reg_addr == REG_ENABLE) enable_d = reg_wdata;
    w1c          = (reg_we && reg_addr == REG_PENDING) ? reg_wdata : '0;
    last_grant_d = ack_take ? irq_id_q : last_grant_q;
    pending_d    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        // Clear first, then set: a new edge beats a simultaneous clear.
        pending_d[i] = (pending_q[i] & ~(w1c[i] | (ack_take && irq_id_q == ID_W'(i))))
                     | (src_i[i] & ~src_q[i]);
      end else begin
        pending_d[i] = src_i[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: if (any) begin
        state_d  = REQ;
        irq_id_d = sel_id;
      end
      // Ack takes precedence over a withdrawal in the same cycle.
      REQ: begin
        if (irq_ack)              state_d = ACTIVE;
        else if (!cand[irq_id_q]) state_d = IDLE;
      end
      ACTIVE: if (irq_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    irq_valid = (state_q == REQ);
    reg_rdata = '0;
    case (reg_addr)
      REG_ENABLE:    reg_rdata = enable_q;
      REG_PENDING:   reg_rdata = pending_q;
      REG_ACTIVE_ID: if (state_q != IDLE) reg_rdata[ID_W-1:0] = irq_id_q;
      default:       reg_rdata = '0;
    endcase
  end

  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_f, src_r;
  logic          reg_we;
  logic [1:0]    reg_addr;
  logic [N-1:0]  reg_wdata;
  logic [N-1:0]  rdata_f, rdata_r;
  logic          valid_f, valid_r;
  logic [IW-1:0] id_f, id_r;
  logic          irq_ack, irq_done;

  int checks = 0, errors = 0;
  bit use_rr = 1'b0;
  logic [IW-1:0] exp_f[$], exp_r[$];
  logic pv_f = 1'b0, pv_r = 1'b0;

  always #5 clk = ~clk;

  // Fixed-priority, all-edge instance.
  irq_ctrl #(.NUM_SRC(N)) u_dut (
    .clk(clk), .rst(rst), .src_i(src_f), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(rdata_f), .irq_valid(valid_f), .irq_id(id_f),
    .irq_ack(irq_ack), .irq_done(irq_done));

  // Round-robin, all-level instance.
  irq_ctrl #(.NUM_SRC(N), .EDGE_MASK(4'b0000), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .src_i(src_r), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(rdata_r), .irq_valid(valid_r), .irq_id(id_r),
    .irq_ack(irq_ack), .irq_done(irq_done));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each new request must match the next queued ID.
  always @(negedge clk) begin
    if (valid_f && !pv_f) begin
      if (exp_f.size() == 0) chk("sb_f_extra", 1, 0);
      else chk("sb_f_id", id_f, exp_f.pop_front());
    end
    if (valid_r && !pv_r) begin
      if (exp_r.size() == 0) chk("sb_r_extra", 1, 0);
      else chk("sb_r_id", id_r, exp_r.pop_front());
    end
    pv_f = valid_f;
    pv_r = valid_r;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic cur_valid();
    return use_rr ? valid_r : valid_f;
  endfunction

  function automatic logic [IW-1:0] cur_id();
    return use_rr ? id_r : id_f;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cyc(1);
    reg_we = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [N-1:0] e);
    logic [N-1:0] d;
    reg_addr = a;
    #1;
    d = use_rr ? rdata_r : rdata_f;
    chk(tag, d, e);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!cur_valid() && n < 20) begin
      cyc(1);
      n++;
    end
    chk(tag, cur_valid(), 1);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
  endtask

  task automatic do_done();
    irq_done = 1'b1; cyc(1); irq_done = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; src_f = '0; src_r = '0; reg_we = 1'b0; reg_addr = '0;
    reg_wdata = '0; irq_ack = 1'b0; irq_done = 1'b0;
    cyc(2);
    rst = 1'b0;

    // Reset state
    chk("rst_valid", valid_f, 0);
    chk("rst_id", id_f, 0);
    chk_reg("rst_en", REG_ENABLE, 4'h0);
    chk_reg("rst_pend", REG_PENDING, 4'h0);
    chk_reg("rst_aid", REG_ACTIVE_ID, 4'h0);
    chk_reg("rsvd_rd", 2'd3, 4'h0);

    wr(REG_ENABLE, 4'hF);
    chk_reg("en_rb", REG_ENABLE, 4'hF);

    // Basic edge request, 2-cycle latency
    exp_f.push_back(2'd2);
    src_f = 4'b0100; cyc(1); src_f = '0;
    chk("e_lat1", valid_f, 0);
    chk_reg("e_pend", REG_PENDING, 4'b0100);
    cyc(1);
    chk("e_lat2", valid_f, 1);
    chk("e_id", id_f, 2);
    chk_reg("e_aid_req", REG_ACTIVE_ID, 4'd2);
    do_ack();
    chk("ack_vld", valid_f, 0);
    chk_reg("ack_pend", REG_PENDING, 4'h0);
    chk_reg("ack_aid", REG_ACTIVE_ID, 4'd2);
    do_done();
    chk_reg("done_aid", REG_ACTIVE_ID, 4'd0);
    chk_reg("done_pend", REG_PENDING, 4'h0);

    // Fixed priority
    exp_f.push_back(2'd1); exp_f.push_back(2'd3);
    src_f = 4'b1010; cyc(1); src_f = '0;
    chk_reg("fp_pend0", REG_PENDING, 4'b1010);
    wait_valid("fp_v1"); chk("fp_id1", id_f, 1);
    do_ack(); chk_reg("fp_pend1", REG_PENDING, 4'b1000);
    do_done();
    wait_valid("fp_v2"); chk("fp_id2", id_f, 3);
    do_ack(); chk_reg("fp_pend2", REG_PENDING, 4'h0);
    do_done();

    // W1C on its own, with requests masked
    wr(REG_ENABLE, 4'h0);
    src_f = 4'b1000; cyc(1); src_f = '0;
    chk_reg("w1c_set", REG_PENDING, 4'b1000);
    wr(REG_PENDING, 4'b1000);
    chk_reg("w1c_clr", REG_PENDING, 4'h0);
    chk("w1c_novld", valid_f, 0);
    wr(REG_ENABLE, 4'hF);

    // Withdrawal by disabling
    exp_f.push_back(2'd1); exp_f.push_back(2'd1);
    src_f = 4'b0010; cyc(1); src_f = '0;
    wait_valid("wd_v1");
    wr(REG_ENABLE, 4'h0);
    cyc(1);
    chk("wd_vld", valid_f, 0);
    chk_reg("wd_aid", REG_ACTIVE_ID, 4'd0);
    chk_reg("wd_pend", REG_PENDING, 4'b0010);
    wr(REG_ENABLE, 4'hF);
    wait_valid("wd_v2"); chk("wd_id2", id_f, 1);
    // Ack in the same cycle as the disabling write: ack wins
    reg_we = 1'b1; reg_addr = REG_ENABLE; reg_wdata = 4'h0; irq_ack = 1'b1;
    cyc(1);
    reg_we = 1'b0; irq_ack = 1'b0;
    chk("aw_vld", valid_f, 0);
    chk_reg("aw_aid", REG_ACTIVE_ID, 4'd1);
    chk_reg("aw_pend", REG_PENDING, 4'h0);
    do_done();
    wr(REG_ENABLE, 4'hF);

    // Set/clear collision: new edge wins over W1C
    exp_f.push_back(2'd0);
    src_f = 4'b0001; reg_we = 1'b1; reg_addr = REG_PENDING; reg_wdata = 4'b0001;
    cyc(1);
    reg_we = 1'b0; src_f = '0;
    chk_reg("col_pend", REG_PENDING, 4'b0001);
    wait_valid("col_v"); chk("col_id", id_f, 0);
    do_ack(); do_done();

    // Reset while ACTIVE
    exp_f.push_back(2'd2);
    src_f = 4'b0100; cyc(1); src_f = '0;
    wait_valid("ra_v");
    do_ack();
    src_f = 4'b0010; cyc(1); src_f = '0;
    chk_reg("ra_pend", REG_PENDING, 4'b0010);
    chk_reg("ra_aid", REG_ACTIVE_ID, 4'd2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("ra_vld", valid_f, 0);
    chk_reg("ra_aid0", REG_ACTIVE_ID, 4'd0);
    chk_reg("ra_pend0", REG_PENDING, 4'h0);
    chk_reg("ra_en0", REG_ENABLE, 4'h0);
    cyc(2);
    chk("ra_idle", valid_f, 0);

    // Round-robin on level sources
    use_rr = 1'b1;
    foreach (rr_seq[i]) exp_r.push_back(rr_seq[i]);
    src_r = 4'hF;
    wr(REG_ENABLE, 4'hF);
    foreach (rr_seq[i]) begin
      wait_valid("rr_v");
      chk("rr_id", id_r, {30'd0, rr_seq[i]});
      do_ack();
      chk_reg("rr_lvl_pend", REG_PENDING, 4'hF);
      do_done();
    end
    // Level still high after done: re-requested exactly 2 cycles on
    exp_r.push_back(2'd1);
    chk("lvl_d0", valid_r, 0);
    cyc(1);
    chk("lvl_d1", valid_r, 1);
    chk("lvl_id", id_r, 1);
    do_ack();
    src_r = '0;
    do_done();
    cyc(3);
    chk("lvl_quiet", valid_r, 0);

    chk("sb_f_left", exp_f.size(), 0);
    chk("sb_r_left", exp_r.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller in front of the pipelined RISC-V core, generalising the core's fixed two-line `interrupt` input to `NUM_SRC` sources. It supports per-source edge or level sensitivity, enable masking, and fixed or round-robin priority. It presents a single request/acknowledge/done handshake to the core's trap logic. Software controls it through a small register port driven from the core's data-memory path.

## Interface
- `NUM_SRC`, 4: number of interrupt sources; legal range 2..32.
- `EDGE_MASK`, all ones: bit i = 1 makes source i rising-edge sensitive; 0 makes it level sensitive.
- `RR_EN`, 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- `ID_W`, $clog2(NUM_SRC): width of the source ID; derived, do not override.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `src_i`  in  NUM_SRC  interrupt source lines, already synchronous to `clk`.
- `reg_we`  in  1  register write strobe.
- `reg_addr`  in  2  register select: 0 ENABLE, 1 PENDING, 2 ACTIVE_ID, 3 reserved.
- `reg_wdata`  in  NUM_SRC  write data.
- `reg_rdata`  out  NUM_SRC  combinational read data for `reg_addr`.
- `irq_valid`  out  1  interrupt request to the core.
- `irq_id`  out  ID_W  ID of the requested or active source.
- `irq_ack`  in  1  core takes the trap; only meaningful while `irq_valid`.
- `irq_done`  in  1  core executed `mret`; only meaningful in ACTIVE.

## Operation
- **ENABLE register:** read/write.
- **PENDING register:** read; write-1-to-clear for edge sources only.
- **ACTIVE_ID register:** read-only; reads zero-extended `irq_id` in REQ/ACTIVE and 0 in IDLE.
- **Reserved address:** reads 0; writes are ignored.
- **Edge source i:** `src_q[i]` holds the previous sample. `pending[i]` sets when `src_i[i] & ~src_q[i]`.
  - Clears on a W1C write, or on `irq_ack` while `irq_id == i`.
  - If set and clear occur in the same cycle, set wins.
- **Level source i:** `pending[i]` is loaded with `src_i[i]` every cycle. W1C writes and ack have no effect on it.
- **Candidates:** `cand = pending & enable`.
- **Fixed priority:** the lowest set index of `cand` is selected.
- **Round-robin:** the search starts at `last_grant+1` mod NUM_SRC. `last_grant` updates on `irq_ack`.
- **FSM state IDLE:**
  - If `cand != 0`, latch the selected ID into `irq_id` and go to REQ.
- **FSM state REQ:**
  - `irq_valid = 1`; `irq_id` is held stable.
  - On `irq_ack`, go to ACTIVE.
  - Otherwise, if `cand[irq_id]` drops (source disabled or cleared), withdraw and go to IDLE.
  - If `irq_ack` and withdrawal occur in the same cycle, ack wins.
- **FSM state ACTIVE:**
  - `irq_valid = 0`; `irq_id` is held.
  - On `irq_done`, go to IDLE.
  - No nesting: new pendings accumulate but are not requested.
- **Ignored inputs:** `irq_ack` outside REQ and `irq_done` outside ACTIVE are ignored.

## Timing
- **Reset values:**
  - State IDLE; `irq_valid` 0; `irq_id` 0.
  - `enable`, `pending` and `src_q` all 0.
  - `last_grant` = NUM_SRC-1, so round-robin searches from index 0 first.
- **Request latency:** edge seen at posedge t sets pending at t. FSM enters REQ at t+1, so `irq_valid` is high in the cycle after t+1. Latency is 2 cycles from sampled edge to `irq_valid`.
- **Register writes:** take effect at the same edge. A new ENABLE value affects arbitration from the next cycle.
- **Read data:** `reg_rdata` is combinational, same cycle.
- **Acknowledge:** `irq_valid` falls the cycle after `irq_ack` is sampled.
- **After `irq_done`:** there is at least one IDLE cycle, so back-to-back requests are spaced by at least 2 cycles.
- **Level source still high after done:** it is re-requested 2 cycles after `irq_done`.
- **`rst` mid-operation:** in REQ or ACTIVE it returns to IDLE at that edge. Pendings are lost; no request is outstanding.

## Structure
- **Package `irq_ctrl_pkg`:**
  - `irq_state_t` enum {IDLE, REQ, ACTIVE}.
  - Register address constants `REG_ENABLE`, `REG_PENDING`, `REG_ACTIVE_ID`.
- **Sub-module `irq_arbiter`:** combinational. Inputs `cand`, `last_grant`, `RR_EN`; outputs `sel_id` and `any`. Instantiated once.
- **Top level:** FSM, pending/enable/edge registers and the register port remain in `irq_ctrl`.

## Test plan
- **Basic edge request:** NUM_SRC=4, ENABLE=4'b1111; pulse `src_i[2]` for 1 cycle.
  - `irq_valid` is high 2 cycles later with `irq_id`=2.
  - Ack clears PENDING bit 2; `irq_done` returns to IDLE with PENDING=0.
- **Fixed priority:** raise sources 3 and 1 simultaneously.
  - First `irq_id`=1; after done, `irq_id`=3.
  - PENDING reads 4'b1010, then 4'b1000, then 0.
- **Round-robin:** RR_EN=1 with sources 0..3 all level-high.
  - Successive ack/done cycles grant IDs 0,1,2,3,0.
- **Withdrawal:**
  - While in REQ for ID 1, write ENABLE=0: `irq_valid` drops next cycle and state is IDLE.
  - Repeat with `irq_ack` in the same cycle as the write: ack wins and state is ACTIVE.
- **Set/clear collision and level behaviour:**
  - Pulse source 0 and W1C bit 0 in the same cycle: PENDING[0] stays 1.
  - Level source held high after `irq_done`: re-requested exactly 2 cycles later.
- **Reset in ACTIVE:** assert `rst` for 1 cycle.
  - `irq_valid`=0, ACTIVE_ID reads 0, PENDING=0 and ENABLE=0 at the next cycle.
